// File: rtl/irqmp_prio_pkg.sv
// irqmp_prio_pkg: shared types and constants for the multithreaded interrupt
// controller.
//   - Thread-ID width and IO address width used by the IU slice.
//   - iu_clk_type: the clock bundle; only .clk is used.
//   - irqmp_sel_type / irqmp_sel_t: what each thread's IRL table entry refers
//     to (nothing, the IPI, or a device source index).
//   - Register offsets within the block's 256-byte window.
package irqmp_prio_pkg;

  localparam int NTHREADIDMSB = 1;
  localparam int TIDW         = NTHREADIDMSB + 1;
  localparam int NTHREAD      = 1 << TIDW;
  localparam int IO_AWIDTH    = 12;
  localparam int SRC_IDW      = 4;

  typedef struct packed {
    logic clk;
  } iu_clk_type;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_IPI  = 2'd1,
    SEL_SRC  = 2'd2
  } irqmp_sel_type;

  typedef logic [SRC_IDW-1:0] irqmp_src_t;

  typedef struct packed {
    irqmp_sel_type kind;
    irqmp_src_t    src;
  } irqmp_sel_t;

  localparam irqmp_sel_t SEL_NONE_V = '{kind: SEL_NONE, src: '0};

  localparam logic [7:0] IRQMP_SRC_BASE = 8'h00;
  localparam logic [7:0] IRQMP_IPI      = 8'h40;
  localparam logic [7:0] IRQMP_MASK     = 8'h44;
  localparam logic [7:0] IRQMP_FORCE    = 8'h48;

endpackage

// File: rtl/irqmp_prio_arb.sv
// irqmp_prio_arb: combinational priority encoder for one thread.
//   cand_i  : pending & mask bits of the thread, one per source
//   level_i : packed 4-bit LEVEL per source (source s at [4*s +: 4])
//   ipi_i   : thread has an inter-processor interrupt pending
//   irl_o   : winning IRL (0 when nothing is eligible)
//   sel_o   : what the winner is (NONE / IPI / SRC with index)
// The highest non-zero LEVEL wins; ties go to the lowest index. A pending IPI
// overrides every device source regardless of level.
module irqmp_prio_arb
  import irqmp_prio_pkg::*;
#(
  parameter int NIRQ      = 4,
  parameter int IPI_LEVEL = 14
) (
  input  logic [NIRQ-1:0]   cand_i,
  input  logic [NIRQ*4-1:0] level_i,
  input  logic              ipi_i,
  output logic [3:0]        irl_o,
  output irqmp_sel_t        sel_o
);

  always_comb begin
    logic [3:0] best;
    best  = '0;
    sel_o = SEL_NONE_V;
    // Strict '>' keeps the lowest index on a tie; starting at 0 excludes LEVEL=0.
    for (int s = 0; s < NIRQ; s++) begin
      if (cand_i[s] && (level_i[s*4 +: 4] > best)) begin
        best  = level_i[s*4 +: 4];
        sel_o = '{kind: SEL_SRC, src: irqmp_src_t'(s)};
      end
    end
    if (ipi_i) begin
      best  = 4'(IPI_LEVEL);
      sel_o = '{kind: SEL_IPI, src: '0};
    end
    irl_o = best;
  end

endmodule

// File: rtl/irqmp_prio.sv
// irqmp_prio: multithreaded interrupt controller for the pipelined IU.
//   gclk      : clock bundle (gclk.clk)
//   rst       : synchronous active-low reset
//   rd_tid    : thread issuing in M1; irl is its table entry
//   irl       : 4-bit IRL for rd_tid
//   irqack    : thread ack_tid took its interrupt trap (XC)
//   ack_tid   : acknowledging thread
//   cfg_en/cfg_rw/cfg_addr/cfg_wdata : configuration write port
//   irq       : device interrupt lines, synchronous to gclk.clk
// A scan counter re-arbitrates one thread per cycle into an IRL table; the
// acknowledge clears the source that table entry recorded.
module irqmp_prio
  import irqmp_prio_pkg::*;
#(
  parameter int         NIRQ      = 4,
  parameter int         IPI_LEVEL = 14,
  parameter logic [3:0] ADDRMASK  = 4'b0
) (
  input  iu_clk_type               gclk,
  input  logic                     rst,
  input  logic [NTHREADIDMSB:0]    rd_tid,
  output logic [3:0]               irl,
  input  logic                     irqack,
  input  logic [NTHREADIDMSB:0]    ack_tid,
  input  logic                     cfg_en,
  input  logic                     cfg_rw,
  input  logic [IO_AWIDTH-1:0]     cfg_addr,
  input  logic [31:0]              cfg_wdata,
  input  logic [NIRQ-1:0]          irq
);

  logic [NIRQ-1:0]    pend_q    [NTHREAD];
  logic [NIRQ-1:0]    pend_d    [NTHREAD];
  logic [NTHREAD-1:0] ipi_q, ipi_d;
  logic [NIRQ-1:0]    mask_q    [NTHREAD];
  logic [NIRQ-1:0]    mask_d    [NTHREAD];
  logic [3:0]         level_q   [NIRQ];
  logic [3:0]         level_d   [NIRQ];
  logic [NIRQ-1:0]    edge_mode_q, edge_mode_d;
  logic [TIDW-1:0]    route_q   [NIRQ];
  logic [TIDW-1:0]    route_d   [NIRQ];
  logic [3:0]         irl_tab_q [NTHREAD];
  logic [3:0]         irl_tab_d [NTHREAD];
  irqmp_sel_t         sel_q     [NTHREAD];
  irqmp_sel_t         sel_d     [NTHREAD];
  logic [TIDW-1:0]    scan_q, scan_d;
  logic [NIRQ-1:0]    prev_q, prev_d;

  // Configuration decode
  logic            blk_wr;
  logic [7:0]      off;
  logic            wr_src, wr_ipi, wr_mask, wr_force;
  logic [TIDW-1:0] wr_tid, ipi_tid;

  assign blk_wr   = cfg_en & cfg_rw & (cfg_addr[IO_AWIDTH-1 -: 4] == ADDRMASK);
  assign off      = cfg_addr[7:0];
  assign wr_src   = blk_wr && (off[7:6] == 2'b00) && (off[1:0] == 2'b00) &&
                    ({1'b0, off[5:2]} < 5'(NIRQ));
  assign wr_ipi   = blk_wr && (off == IRQMP_IPI);
  assign wr_mask  = blk_wr && (off == IRQMP_MASK);
  assign wr_force = blk_wr && (off == IRQMP_FORCE);
  assign wr_tid   = cfg_wdata[16 +: TIDW];
  assign ipi_tid  = cfg_wdata[TIDW-1:0];

  logic unused_bits;
  assign unused_bits = ^{cfg_wdata, cfg_addr};

  // Event capture uses the registered EDGE/ROUTE, so a same-cycle config
  // write only affects later captures.
  logic [NIRQ-1:0] hit;
  always_comb begin
    hit = '0;
    for (int s = 0; s < NIRQ; s++) begin
      hit[s] = edge_mode_q[s] ? (irq[s] & ~prev_q[s]) : irq[s];
    end
  end

  // Arbitration of the scanned thread
  logic [NIRQ*4-1:0] level_pk;
  logic [3:0]        arb_irl;
  irqmp_sel_t        arb_sel;

  always_comb begin
    level_pk = '0;
    for (int s = 0; s < NIRQ; s++) begin
      level_pk[s*4 +: 4] = level_q[s];
    end
  end

  irqmp_prio_arb #(
    .NIRQ      (NIRQ),
    .IPI_LEVEL (IPI_LEVEL)
  ) u_arb (
    .cand_i  (pend_q[scan_q] & mask_q[scan_q]),
    .level_i (level_pk),
    .ipi_i   (ipi_q[scan_q]),
    .irl_o   (arb_irl),
    .sel_o   (arb_sel)
  );

  // Per-thread next state
  irqmp_sel_t ack_sel;
  assign ack_sel = sel_q[ack_tid];

  always_comb begin
    logic [NIRQ-1:0] set_v;
    logic [NIRQ-1:0] clr_v;
    logic            ack_here;
    ipi_d = ipi_q;
    for (int t = 0; t < NTHREAD; t++) begin
      ack_here = irqack && (ack_tid == TIDW'(t));
      set_v    = '0;
      clr_v    = '0;
      for (int s = 0; s < NIRQ; s++) begin
        if (hit[s] && (route_q[s] == TIDW'(t))) set_v[s] = 1'b1;
        if (ack_here && (ack_sel.kind == SEL_SRC) && (ack_sel.src == irqmp_src_t'(s)))
          clr_v[s] = 1'b1;
      end
      if (wr_force && (wr_tid == TIDW'(t))) set_v = set_v | cfg_wdata[NIRQ-1:0];
      // Clear first, then set: a coincident set is never lost.
      pend_d[t] = (pend_q[t] & ~clr_v) | set_v;
      ipi_d[t]  = (ipi_q[t] & ~(ack_here && (ack_sel.kind == SEL_IPI))) |
                  (wr_ipi && (ipi_tid == TIDW'(t)));
      mask_d[t] = (wr_mask && (wr_tid == TIDW'(t))) ? cfg_wdata[NIRQ-1:0] : mask_q[t];

      irl_tab_d[t] = irl_tab_q[t];
      sel_d[t]     = sel_q[t];
      if (scan_q == TIDW'(t)) begin
        irl_tab_d[t] = arb_irl;
        sel_d[t]     = arb_sel;
      end
      // The ack overrides a same-cycle scan so the taken interrupt is not
      // presented again before it has been re-arbitrated.
      if (ack_here) begin
        irl_tab_d[t] = '0;
        sel_d[t]     = SEL_NONE_V;
      end
    end
  end

  // Per-source configuration
  always_comb begin
    edge_mode_d = edge_mode_q;
    for (int s = 0; s < NIRQ; s++) begin
      level_d[s] = level_q[s];
      route_d[s] = route_q[s];
      if (wr_src && (off[5:2] == 4'(s))) begin
        level_d[s]     = cfg_wdata[3:0];
        edge_mode_d[s] = cfg_wdata[4];
        route_d[s]     = cfg_wdata[8 +: TIDW];
      end
    end
  end

  assign scan_d = scan_q + 1'b1;
  assign prev_d = irq;

  always_ff @(posedge gclk.clk) begin
    if (!rst) begin
      pend_q      <= '{default: '0};
      ipi_q       <= '0;
      mask_q      <= '{default: '1};
      level_q     <= '{default: '0};
      edge_mode_q <= '0;
      route_q     <= '{default: '0};
      irl_tab_q   <= '{default: '0};
      sel_q       <= '{default: SEL_NONE_V};
      scan_q      <= '0;
      prev_q      <= '0;
    end else begin
      pend_q      <= pend_d;
      ipi_q       <= ipi_d;
      mask_q      <= mask_d;
      level_q     <= level_d;
      edge_mode_q <= edge_mode_d;
      route_q     <= route_d;
      irl_tab_q   <= irl_tab_d;
      sel_q       <= sel_d;
      scan_q      <= scan_d;
      prev_q      <= prev_d;
    end
  end

  assign irl = irl_tab_q[rd_tid];

endmodule

// File: tb/tb_irqmp_prio.sv
// tb_irqmp_prio: scoreboard bench for irqmp_prio. Stimulus pushes the
// expected IRL of each lookup into a queue; a monitor pops and compares on
// the falling edge while a lookup is presented.
module tb_irqmp_prio;
  import irqmp_prio_pkg::*;

  localparam int         NIRQ    = 4;
  localparam int         IPI_LVL = 14;
  localparam logic [3:0] AMASK   = 4'h0;
  localparam int         SETTLE  = NTHREAD + 2;

  logic                 clk = 1'b0;
  iu_clk_type           gclk;
  logic                 rst;
  logic [TIDW-1:0]      rd_tid;
  logic [3:0]           irl;
  logic                 irqack;
  logic [TIDW-1:0]      ack_tid;
  logic                 cfg_en;
  logic                 cfg_rw;
  logic [IO_AWIDTH-1:0] cfg_addr;
  logic [31:0]          cfg_wdata;
  logic [NIRQ-1:0]      irq;

  always #5 clk = ~clk;
  assign gclk.clk = clk;

  irqmp_prio #(.NIRQ(NIRQ), .IPI_LEVEL(IPI_LVL), .ADDRMASK(AMASK)) dut (
    .gclk(gclk), .rst(rst), .rd_tid(rd_tid), .irl(irl), .irqack(irqack),
    .ack_tid(ack_tid), .cfg_en(cfg_en), .cfg_rw(cfg_rw), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .irq(irq)
  );

  // Reference model state
  bit [NIRQ-1:0] m_pend [NTHREAD];
  bit            m_ipi  [NTHREAD];
  bit [NIRQ-1:0] m_mask [NTHREAD];
  int            m_level[NIRQ];
  bit            m_edge [NIRQ];
  int            m_route[NIRQ];
  bit [NIRQ-1:0] m_prev;

  function automatic int model_irl(int t);
    int best = 0;
    if (m_ipi[t]) return IPI_LVL;
    for (int s = 0; s < NIRQ; s++)
      if (m_pend[t][s] && m_mask[t][s] && m_level[s] > best) best = m_level[s];
    return best;
  endfunction

  // -1: nothing, NIRQ: the IPI, otherwise the winning source index.
  function automatic int model_win(int t);
    int b;
    if (m_ipi[t]) return NIRQ;
    b = model_irl(t);
    if (b == 0) return -1;
    for (int s = 0; s < NIRQ; s++)
      if (m_pend[t][s] && m_mask[t][s] && m_level[s] == b) return s;
    return -1;
  endfunction

  task automatic model_update();
    bit [NIRQ-1:0] set_p[NTHREAD];
    bit [NIRQ-1:0] clr_p[NTHREAD];
    bit            set_i[NTHREAD];
    bit            clr_i[NTHREAD];
    bit            hitb;
    int            w, s;
    logic [7:0]    o;
    if (!rst) begin
      for (int t = 0; t < NTHREAD; t++) begin
        m_pend[t] = '0; m_ipi[t] = 0; m_mask[t] = '1;
      end
      for (int k = 0; k < NIRQ; k++) begin
        m_level[k] = 0; m_edge[k] = 0; m_route[k] = 0;
      end
      m_prev = '0;
      return;
    end
    for (int t = 0; t < NTHREAD; t++) begin
      set_p[t] = '0; clr_p[t] = '0; set_i[t] = 0; clr_i[t] = 0;
    end
    for (int k = 0; k < NIRQ; k++) begin
      hitb = m_edge[k] ? (irq[k] && !m_prev[k]) : irq[k];
      if (hitb) set_p[m_route[k]][k] = 1'b1;
    end
    if (irqack) begin
      w = model_win(int'(ack_tid));
      if (w == NIRQ) clr_i[ack_tid] = 1;
      else if (w >= 0) clr_p[ack_tid][w] = 1'b1;
    end
    if (cfg_en && cfg_rw && cfg_addr[IO_AWIDTH-1 -: 4] == AMASK) begin
      o = cfg_addr[7:0];
      if (o[1:0] == 2'b00 && int'(o) < 4 * NIRQ) begin
        s = int'(o) / 4;
        m_level[s] = int'(cfg_wdata[3:0]);
        m_edge[s]  = cfg_wdata[4];
        m_route[s] = int'(cfg_wdata[8 +: TIDW]);
      end else if (o == 8'h40) set_i[cfg_wdata[TIDW-1:0]] = 1;
      else if (o == 8'h44) m_mask[cfg_wdata[16 +: TIDW]] = cfg_wdata[NIRQ-1:0];
      else if (o == 8'h48) set_p[cfg_wdata[16 +: TIDW]] |= cfg_wdata[NIRQ-1:0];
    end
    for (int t = 0; t < NTHREAD; t++) begin
      m_pend[t] = (m_pend[t] & ~clr_p[t]) | set_p[t];
      m_ipi[t]  = (m_ipi[t] && !clr_i[t]) || set_i[t];
    end
    m_prev = irq;
  endtask

  // Scoreboard
  typedef struct { int tid; int irl; } exp_t;
  exp_t  exp_q[$];
  exp_t  mon_e;
  logic  look_vld = 1'b0;
  int    n_cmp = 0;
  int    n_bad = 0;
  string phase = "init";

  always @(negedge clk) begin
    if (look_vld) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL %s: lookup with no queued expectation, irl=%0d", phase, irl);
      end else begin
        mon_e = exp_q.pop_front();
        if (irl !== 4'(mon_e.irl)) begin
          n_bad++;
          $display("FAIL %s irl tid=%0d: got %0d, expected %0d", phase, mon_e.tid, irl, mon_e.irl);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
    look_vld = 1'b0;
    irqack   = 1'b0;
    cfg_en   = 1'b0;
    cfg_rw   = 1'b0;
  endtask

  task automatic lookup_exp(int t, int e);
    rd_tid = TIDW'(t);
    exp_q.push_back('{tid: t, irl: e});
    look_vld = 1'b1;
    tick();
  endtask

  task automatic check_all();
    repeat (SETTLE) tick();
    for (int t = 0; t < NTHREAD; t++) lookup_exp(t, model_irl(t));
  endtask

  task automatic cfg_write(logic [7:0] o, logic [31:0] d,
                           logic [3:0] blk = AMASK, logic rw = 1'b1);
    cfg_en    = 1'b1;
    cfg_rw    = rw;
    cfg_addr  = '0;
    cfg_addr[IO_AWIDTH-1 -: 4] = blk;
    cfg_addr[7:0] = o;
    cfg_wdata = d;
    tick();
  endtask

  task automatic do_ack(int t);
    irqack  = 1'b1;
    ack_tid = TIDW'(t);
    tick();
    lookup_exp(t, 0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  logic [7:0] offs [13] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h40, 8'h44, 8'h48,
                            8'h48, 8'h40, 8'h02, 8'h10, 8'h4C, 8'h80};

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int at;
    bit did_ack;
    rst = 1'b0; rd_tid = '0; irqack = 1'b0; ack_tid = '0; cfg_en = 1'b0;
    cfg_rw = 1'b0; cfg_addr = '0; cfg_wdata = '0; irq = '0;
    tick(); tick();
    rst = 1'b1;

    phase = "reset";
    for (int t = 0; t < NTHREAD; t++) lookup_exp(t, 0);

    phase = "edge_route";
    do_reset();
    cfg_write(8'h08, 32'h0000_0319);          // LEVEL=9, edge, ROUTE=3
    irq[2] = 1'b1; tick(); irq = '0;
    check_all();
    do_ack(3);
    check_all();

    phase = "prio_order";
    do_reset();
    cfg_write(8'h00, 32'h0000_0105);          // src0 LEVEL=5 -> t1
    cfg_write(8'h04, 32'h0000_010C);          // src1 LEVEL=12 -> t1
    cfg_write(8'h48, 32'h0001_0003);          // force src0,src1 on t1
    check_all();
    do_ack(1);
    check_all();
    do_ack(1);
    check_all();

    phase = "ipi_over_15";
    do_reset();
    cfg_write(8'h0C, 32'h0000_020F);          // src3 LEVEL=15 -> t2
    cfg_write(8'h48, 32'h0002_0008);
    cfg_write(8'h40, 32'h0000_0002);
    check_all();
    do_ack(2);
    check_all();

    phase = "level_mode";
    do_reset();
    cfg_write(8'h00, 32'h0000_0007);
    irq[0] = 1'b1;
    check_all();
    do_ack(0);
    check_all();
    irq = '0; tick();
    do_ack(0);
    check_all();

    phase = "mask";
    do_reset();
    cfg_write(8'h44, 32'h0000_0000);          // MASK[0]=0
    cfg_write(8'h04, 32'h0000_0006);
    cfg_write(8'h48, 32'h0000_0002);
    check_all();
    cfg_write(8'h44, 32'h0000_0002);
    check_all();

    phase = "ack_vs_edge";
    do_reset();
    cfg_write(8'h04, 32'h0000_001A);          // src1 LEVEL=10, edge, t0
    irq[1] = 1'b1; tick(); irq = '0;
    check_all();
    irq[1] = 1'b1; irqack = 1'b1; ack_tid = '0; tick(); irq = '0;
    lookup_exp(0, 0);
    check_all();

    phase = "mid_reset";
    rst = 1'b0; irqack = 1'b1; ack_tid = '0;
    cfg_en = 1'b1; cfg_rw = 1'b1; cfg_addr = '0; cfg_addr[7:0] = 8'h48;
    cfg_wdata = 32'h0000_000F;
    tick();
    rst = 1'b1;
    for (int t = 0; t < NTHREAD; t++) lookup_exp(t, 0);
    cfg_write(8'h04, 32'h0000_000A);          // pending bits must be gone
    check_all();

    phase = "random";
    do_reset();
    for (int i = 0; i < 150; i++) begin
      irq = NIRQ'($urandom) & NIRQ'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        cfg_en    = 1'b1;
        cfg_rw    = ($urandom_range(0, 7) != 0);
        cfg_addr  = '0;
        cfg_addr[IO_AWIDTH-1 -: 4] = ($urandom_range(0, 7) == 0) ?
                                     4'($urandom_range(1, 15)) : AMASK;
        cfg_addr[7:0] = offs[$urandom_range(0, 12)];
        cfg_wdata = $urandom;
      end
      did_ack = ($urandom_range(0, 2) == 0);
      at = $urandom_range(0, NTHREAD - 1);
      if (did_ack) begin
        irqack  = 1'b1;
        ack_tid = TIDW'(at);
      end
      tick();
      irq = '0;
      if (did_ack) lookup_exp(at, 0);
      check_all();
    end

    phase = "drain";
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
